// File: rtl/ram_arb_pkg.sv
// Shared defaults, FSM state encoding and requester ids for the RAM port arbiter.
package ram_arb_pkg;

  localparam int AW_DEF     = 8;
  localparam int DW_DEF     = 8;
  localparam int RD_LAT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_CLEAR = 2'd2
  } arb_state_e;

  typedef enum logic {
    ID_A = 1'b0,
    ID_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/rd_tag_pipe.sv
// Tracks outstanding reads so each rvalid pulse lands RD_LAT cycles after its
// ram_rden cycle and is steered to the requester that issued the read.
module rd_tag_pipe
  import ram_arb_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    in_valid,
  input  req_id_e in_id,
  output logic    a_rvalid,
  output logic    b_rvalid
);

  logic [RD_LAT-1:0] valid_q, valid_d;
  logic [RD_LAT-1:0] id_q, id_d;

  always_comb begin
    valid_d = (valid_q << 1) | RD_LAT'(in_valid);
    id_d    = (id_q << 1) | RD_LAT'(logic'(in_id));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      id_q    <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  assign a_rvalid = valid_q[RD_LAT-1] && (req_id_e'(id_q[RD_LAT-1]) == ID_A);
  assign b_rvalid = valid_q[RD_LAT-1] && (req_id_e'(id_q[RD_LAT-1]) == ID_B);

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester single-port RAM arbiter with round-robin tie break and a
// zero-fill clear sequence that owns the RAM port while it runs.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic          clk_50M,
  input  logic          RST_N,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          a_gnt,
  output logic          b_gnt,
  output logic          a_rvalid,
  output logic          b_rvalid,
  output logic [DW-1:0] rdata,
  input  logic          clr_start,
  output logic          busy,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  output logic          ram_rden,
  input  logic [DW-1:0] ram_q
);

  arb_state_e    state_q, state_d;
  logic [AW-1:0] ram_address_q, ram_address_d;
  logic [DW-1:0] ram_data_q, ram_data_d;
  logic          ram_wren_q, ram_wren_d;
  logic          ram_rden_q, ram_rden_d;
  logic          a_gnt_q, a_gnt_d;
  logic          b_gnt_q, b_gnt_d;
  logic          busy_q, busy_d;
  req_id_e       last_q, last_d;

  logic          a_elig, b_elig, pick_b, arb_en;

  // A requester still holding req in its own grant cycle is already being served.
  assign a_elig = a_req && !a_gnt_q;
  assign b_elig = b_req && !b_gnt_q;
  assign pick_b = b_elig && (!a_elig || (last_q == ID_A));

  always_comb begin
    state_d       = state_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = 1'b0;
    ram_rden_d    = 1'b0;
    a_gnt_d       = 1'b0;
    b_gnt_d       = 1'b0;
    busy_d        = 1'b0;
    last_d        = last_q;
    arb_en        = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        if (ram_address_q == '1) begin
          state_d = ST_IDLE;
          arb_en  = 1'b1;
        end else begin
          busy_d        = 1'b1;
          ram_wren_d    = 1'b1;
          ram_address_d = ram_address_q + AW'(1);
          ram_data_d    = '0;
        end
      end
      default: begin
        if (clr_start) begin
          state_d       = ST_CLEAR;
          busy_d        = 1'b1;
          ram_wren_d    = 1'b1;
          ram_address_d = '0;
          ram_data_d    = '0;
        end else begin
          arb_en  = 1'b1;
          state_d = (a_elig || b_elig) ? ST_ARB : ST_IDLE;
        end
      end
    endcase

    // The final clear cycle also arbitrates so a waiting request issues immediately.
    if (arb_en && (a_elig || b_elig)) begin
      ram_address_d = pick_b ? b_addr : a_addr;
      ram_data_d    = pick_b ? b_wdata : a_wdata;
      ram_wren_d    = pick_b ? b_we : a_we;
      ram_rden_d    = pick_b ? !b_we : !a_we;
      a_gnt_d       = !pick_b;
      b_gnt_d       = pick_b;
      last_d        = pick_b ? ID_B : ID_A;
    end
  end

  always_ff @(posedge clk_50M or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= ST_IDLE;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      ram_rden_q    <= 1'b0;
      a_gnt_q       <= 1'b0;
      b_gnt_q       <= 1'b0;
      busy_q        <= 1'b0;
      last_q        <= ID_B;
    end else begin
      state_q       <= state_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      ram_rden_q    <= ram_rden_d;
      a_gnt_q       <= a_gnt_d;
      b_gnt_q       <= b_gnt_d;
      busy_q        <= busy_d;
      last_q        <= last_d;
    end
  end

  rd_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_rd_tag_pipe (
    .clk      (clk_50M),
    .rst_n    (RST_N),
    .in_valid (ram_rden_q),
    .in_id    (req_id_e'(b_gnt_q)),
    .a_rvalid (a_rvalid),
    .b_rvalid (b_rvalid)
  );

  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;
  assign ram_rden    = ram_rden_q;
  assign a_gnt       = a_gnt_q;
  assign b_gnt       = b_gnt_q;
  assign busy        = busy_q;
  assign rdata       = (a_rvalid || b_rvalid) ? ram_q : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a 2-cycle-latency RAM model.
module tb_ram_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk_50M = 1'b0;
  logic          RST_N   = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0, clr_start = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid, busy, ram_wren, ram_rden;
  logic [DW-1:0] rdata, ram_data;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_q = '0;

  logic [DW-1:0] mem [256];
  logic [AW-1:0] rd_addr_q = '0;

  int vectors     = 0;
  int miscompares = 0;

  logic          exp_ga, exp_gb, exp_ra, exp_rb;
  logic [DW-1:0] exp_rd;

  always #10 clk_50M = ~clk_50M;

  ram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2)) dut (
    .clk_50M     (clk_50M),
    .RST_N       (RST_N),
    .a_req       (a_req),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .b_req       (b_req),
    .b_we        (b_we),
    .b_addr      (b_addr),
    .b_wdata     (b_wdata),
    .a_gnt       (a_gnt),
    .b_gnt       (b_gnt),
    .a_rvalid    (a_rvalid),
    .b_rvalid    (b_rvalid),
    .rdata       (rdata),
    .clr_start   (clr_start),
    .busy        (busy),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_rden    (ram_rden),
    .ram_q       (ram_q)
  );

  // RAM: address sampled at the end of the rden cycle, data registered one edge later.
  always @(posedge clk_50M) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    rd_addr_q <= ram_address;
    ram_q     <= mem[rd_addr_q];
  end

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_50M);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;

    // Reset values
    applyStimulus(2);
    checkOutput("reset_outputs",
      {a_gnt, b_gnt, a_rvalid, b_rvalid, busy, ram_wren, ram_rden, rdata, ram_address, ram_data}, 32'h0);
    RST_N = 1'b1;

    // A writes 0x5A to 0x10, then reads it back
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h10; a_wdata = 8'h5A;
    applyStimulus(1);
    checkOutput("wr_gnt", {a_gnt, b_gnt, ram_wren, ram_rden}, 32'b1010);
    checkOutput("wr_addr_data", {ram_address, ram_data}, 32'h105A);
    a_we = 1'b0;
    applyStimulus(1);
    checkOutput("held_req_no_reissue", {a_gnt, ram_wren, ram_rden}, 32'h0);
    applyStimulus(1);
    checkOutput("rd_gnt", {a_gnt, b_gnt, ram_wren, ram_rden, ram_address}, {20'h0, 4'b1001, 8'h10});
    a_req = 1'b0;
    applyStimulus(1);
    checkOutput("rd_lat1_addr_hold", {a_rvalid, b_rvalid, ram_rden, ram_address}, {21'h0, 3'b000, 8'h10});
    applyStimulus(1);
    checkOutput("rd_rvalid", {a_rvalid, b_rvalid, rdata}, {22'h0, 2'b10, 8'h5A});
    applyStimulus(1);
    checkOutput("rvalid_one_pulse", {a_rvalid, b_rvalid}, 32'h0);

    // Both read continuously; last grant was A so B wins the first tie
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h20;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h30;
    for (int c = 1; c <= 8; c++) begin
      applyStimulus(1);
      exp_ga = (c <= 6) && (c % 2 == 0);
      exp_gb = (c <= 5) && (c % 2 == 1);
      exp_ra = (c >= 4) && (c % 2 == 0);
      exp_rb = (c >= 3) && (c <= 7) && (c % 2 == 1);
      exp_rd = exp_ra ? 8'h85 : (exp_rb ? 8'h95 : 8'h00);
      checkOutput($sformatf("alt_c%0d", c), {a_gnt, b_gnt, a_rvalid, b_rvalid, rdata},
                  {20'h0, exp_ga, exp_gb, exp_ra, exp_rb, exp_rd});
      if (c == 5) b_req = 1'b0;
      if (c == 6) a_req = 1'b0;
    end

    // Only B, four reads back-to-back from 0x40..0x43
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h40;
    for (int c = 1; c <= 9; c++) begin
      applyStimulus(1);
      exp_gb = (c <= 7) && (c % 2 == 1);
      exp_rb = (c >= 3) && (c % 2 == 1);
      exp_rd = exp_rb ? ((8'h40 + 8'((c - 3) / 2)) ^ 8'hA5) : 8'h00;
      checkOutput($sformatf("b_only_c%0d", c), {a_gnt, b_gnt, a_rvalid, b_rvalid, rdata},
                  {20'h0, 1'b0, exp_gb, 1'b0, exp_rb, exp_rd});
      if (exp_gb) b_addr = 8'h40 + 8'((c + 1) / 2);
      if (c == 7) b_req = 1'b0;
    end

    // Clear with A read pending; a second clr_start mid-clear is ignored
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10; clr_start = 1'b1;
    for (int c = 1; c <= 256; c++) begin
      applyStimulus(1);
      checkOutput($sformatf("clr_c%0d", c),
        {busy, ram_wren, ram_rden, a_gnt, b_gnt, ram_data, ram_address},
        {11'h0, 5'b11000, 8'h00, 8'(c - 1)});
      if (c == 1)   clr_start = 1'b0;
      if (c == 100) clr_start = 1'b1;
      if (c == 101) clr_start = 1'b0;
    end
    applyStimulus(1);
    checkOutput("clr_exit_gnt", {busy, ram_wren, ram_rden, a_gnt, ram_address}, {20'h0, 4'b0011, 8'h10});
    a_req = 1'b0;
    applyStimulus(2);
    checkOutput("clr_readback", {a_rvalid, b_rvalid, rdata}, {22'h0, 2'b10, 8'h00});

    // Read in flight at clr_start, then reset at clear address 0x80
    a_req = 1'b1; a_addr = 8'h30;
    applyStimulus(1);
    checkOutput("pre_clr_gnt", {a_gnt, ram_rden}, 32'b11);
    a_req = 1'b0; clr_start = 1'b1;
    applyStimulus(1);
    clr_start = 1'b0;
    checkOutput("clr2_start", {busy, ram_wren, ram_address}, {22'h0, 2'b11, 8'h00});
    applyStimulus(1);
    checkOutput("inflight_rvalid", {a_rvalid, busy, rdata}, {22'h0, 2'b11, 8'h00});
    applyStimulus(127);
    checkOutput("clr_at_80", {busy, ram_address}, {23'h0, 1'b1, 8'h80});
    #2 RST_N = 1'b0;
    #1;
    checkOutput("rst_mid_clr",
      {a_gnt, b_gnt, a_rvalid, b_rvalid, busy, ram_wren, ram_rden, rdata, ram_address, ram_data}, 32'h0);
    applyStimulus(1);
    RST_N = 1'b1;
    applyStimulus(2);
    checkOutput("no_clear_resume", {busy, ram_wren, ram_rden, a_gnt, b_gnt, a_rvalid, b_rvalid}, 32'h0);

    // Reset between read issue and its rvalid
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h20;
    applyStimulus(1);
    checkOutput("mr_gnt", {a_gnt, ram_rden}, 32'b11);
    a_req = 1'b0;
    #2 RST_N = 1'b0;
    applyStimulus(1);
    RST_N = 1'b1;
    applyStimulus(1);
    checkOutput("no_rvalid_after_rst", {a_rvalid, b_rvalid, rdata}, 32'h0);

    // Tie right after reset release goes to A first, then B
    RST_N = 1'b0;
    applyStimulus(1);
    RST_N = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h01; a_wdata = 8'h11;
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h02; b_wdata = 8'h22;
    applyStimulus(1);
    checkOutput("post_rst_tie_a", {a_gnt, b_gnt, ram_wren, ram_address, ram_data}, {13'h0, 3'b101, 8'h01, 8'h11});
    a_req = 1'b0;
    applyStimulus(1);
    checkOutput("then_b", {a_gnt, b_gnt, ram_wren, ram_address, ram_data}, {13'h0, 3'b011, 8'h02, 8'h22});
    b_req = 1'b0;
    applyStimulus(1);
    checkOutput("idle_hold", {ram_wren, ram_rden, a_gnt, b_gnt, ram_address, ram_data}, {12'h0, 4'b0000, 8'h02, 8'h22});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
